// File: rtl/demux_frame_serializer.sv
// Buffers destination-tagged words in a small FIFO and shifts each one out LSB-first
// on a single serial line, holding the demux channel select stable for the whole frame.
module demux_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [2:0]                  s_dest,
  input  logic [DATA_W-1:0]           s_data,
  output logic                        demux_in,
  output logic [2:0]                  demux_sel,
  output logic                        demux_en,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [2:0]        mem_dest [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;
  logic [CW-1:0]     count_nxt;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_idx;
  logic [3:0]        gap_cnt;
  logic              en_nxt, in_nxt, done_nxt;

  assign push = s_valid && s_ready;
  assign pop  = (state_q == IDLE) && (fifo_count != '0);

  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CW'(1);
      2'b01:   count_nxt = fifo_count - CW'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // FIFO control; s_ready looks one edge ahead so a full FIFO never sees a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      s_ready    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt;
      s_ready    <= (count_nxt < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= s_data;
      mem_dest[wr_ptr] <= s_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SHIFT;
      SHIFT:   if (bit_idx == LAST_BIT) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered serial outputs; shift_reg holds the bits not yet presented
  always_comb begin
    en_nxt   = 1'b0;
    in_nxt   = 1'b0;
    done_nxt = 1'b0;
    case (state_q)
      IDLE: if (pop) begin
        en_nxt = 1'b1;
        in_nxt = mem_data[rd_ptr][0];
      end
      SHIFT: if (bit_idx != LAST_BIT) begin
        en_nxt   = 1'b1;
        in_nxt   = shift_reg[0];
        done_nxt = ((bit_idx + BW'(1)) == LAST_BIT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      demux_en   <= 1'b0;
      demux_in   <= 1'b0;
      frame_done <= 1'b0;
      demux_sel  <= 3'd0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
    end else begin
      demux_en   <= en_nxt;
      demux_in   <= in_nxt;
      frame_done <= done_nxt;
      if (pop) begin
        demux_sel <= mem_dest[rd_ptr];
        bit_idx   <= '0;
      end else if (state_q == SHIFT) begin
        bit_idx <= bit_idx + BW'(1);
      end
      if (state_q == SHIFT)    gap_cnt <= '0;
      else if (state_q == GAP) gap_cnt <= gap_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                    shift_reg <= mem_data[rd_ptr] >> 1;
    else if (state_q == SHIFT)  shift_reg <= shift_reg >> 1;
  end

endmodule

// File: tb/tb_demux_frame_serializer.sv
// Bench for demux_frame_serializer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_demux_frame_serializer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int GAP    = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [2:0]        s_dest = 3'd0;
  logic [DATA_W-1:0] s_data = '0;
  logic              demux_in;
  logic [2:0]        demux_sel;
  logic              demux_en;
  logic              frame_done;
  logic [$clog2(DEPTH):0] fifo_count;

  demux_frame_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_dest(s_dest),
    .s_data(s_data), .demux_in(demux_in), .demux_sel(demux_sel), .demux_en(demux_en),
    .frame_done(frame_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame progress as "cycles since pop" (t)
  logic [DATA_W-1:0] qd[$];
  logic [2:0]        qs[$];
  logic [DATA_W-1:0] sent_d[$];
  logic [2:0]        sent_s[$];
  int                t = 0;
  logic [DATA_W-1:0] cur_data = '0;
  logic [2:0]        e_sel = 3'd0;
  logic              mready = 1'b0;
  logic              pushed_now = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int  sz0;
    logic push;
    if (!rst_n) begin
      qd.delete(); qs.delete();
      t = 0; e_sel = 3'd0; mready = 1'b0; pushed_now = 1'b0;
    end else begin
      sz0  = qd.size();
      push = s_valid && mready;
      if (t == 0) begin
        if (sz0 > 0) begin
          cur_data = qd.pop_front();
          e_sel    = qs.pop_front();
          t = 1;
        end
      end else begin
        t++;
        if (t > DATA_W + GAP) t = 0;
      end
      if (push) begin
        qd.push_back(s_data); qs.push_back(s_dest);
        sent_d.push_back(s_data); sent_s.push_back(s_dest);
      end
      pushed_now = push;
      mready = (qd.size() < DEPTH);
    end
  end

  // Per-cycle compare plus frame reassembly from the serial line
  logic [DATA_W-1:0] out_words[$];
  logic [2:0]        out_dests[$];
  int                done_pos[$];
  int                starts[$];
  int                cyc = 0;

  always @(negedge clk) begin
    logic e_en, e_in, e_done;
    static logic [DATA_W-1:0] bits = '0;
    static int nb = 0;
    static logic prev_en = 1'b0;
    if (!rst_n) begin
      chk("rst_ready", 32'(s_ready), 0);
      chk("rst_en", 32'(demux_en), 0);
      chk("rst_in", 32'(demux_in), 0);
      chk("rst_sel", 32'(demux_sel), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_count", 32'(fifo_count), 0);
      nb = 0; prev_en = 1'b0;
    end else begin
      e_en   = (t >= 1) && (t <= DATA_W);
      e_in   = e_en ? cur_data[t-1] : 1'b0;
      e_done = (t == DATA_W);
      chk("ready", 32'(s_ready), 32'(mready));
      chk("count", 32'(fifo_count), 32'(qd.size()));
      chk("en", 32'(demux_en), 32'(e_en));
      chk("in", 32'(demux_in), 32'(e_in));
      chk("done", 32'(frame_done), 32'(e_done));
      chk("sel", 32'(demux_sel), 32'(e_sel));
      if (demux_en) begin
        if (!prev_en) starts.push_back(cyc);
        if (nb < DATA_W) bits[nb] = demux_in;
        nb++;
        if (frame_done) begin
          out_words.push_back(bits);
          out_dests.push_back(demux_sel);
          done_pos.push_back(nb);
          nb = 0;
        end
      end
      prev_en = demux_en;
    end
    cyc++;
  end

  task automatic push_word(input logic [2:0] d, input logic [DATA_W-1:0] x);
    int k;
    s_valid = 1'b1; s_dest = d; s_data = x;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (pushed_now) break;
    end
    chk("push_accepted", 32'(k < 200), 1);
  endtask

  task automatic idle();
    s_valid = 1'b0; s_data = '0; s_dest = 3'd0;
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    s_valid = 1'b0;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (qd.size() == 0 && t == 0) break;
    end
    chk("drain", 32'(k < 1000), 1);
  endtask

  task automatic wait_t(input int tv);
    int k;
    for (k = 0; k < 200; k++) begin
      if (t == tv) break;
      @(negedge clk);
    end
    chk("wait_phase", 32'(k < 200), 1);
  endtask

  task automatic clear_logs();
    sent_d.delete(); sent_s.delete(); out_words.delete(); out_dests.delete();
    done_pos.delete(); starts.delete();
  endtask

  task automatic check_stream(input string nm);
    chk({nm, "_frames"}, 32'(out_words.size()), 32'(sent_d.size()));
    for (int i = 0; i < sent_d.size(); i++) begin
      if (i < out_words.size()) begin
        chk({nm, "_word"}, 32'(out_words[i]), 32'(sent_d[i]));
        chk({nm, "_dest"}, 32'(out_dests[i]), 32'(sent_s[i]));
        chk({nm, "_donepos"}, 32'(done_pos[i]), DATA_W);
      end
    end
    clear_logs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for 3 cycles, release, s_ready rises one edge later
    repeat (3) @(negedge clk);
    chk("rst_ready_lit", 32'(s_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(s_ready), 1);
    chk("count_after_rst", 32'(fifo_count), 0);

    // Single frame A5 on channel 5: bits 1,0,1,0,0,1,0,1
    clear_logs();
    push_word(3'd5, 8'hA5);
    drain();
    chk("a5_frames", 32'(out_words.size()), 1);
    if (out_words.size() == 1) begin
      chk("a5_word", 32'(out_words[0]), 32'h0000_00A5);
      chk("a5_dest", 32'(out_dests[0]), 5);
      chk("a5_donepos", 32'(done_pos[0]), 8);
    end
    clear_logs();

    // Seven back-to-back words: FIFO fills, frames start every 10 cycles
    for (int i = 0; i < 7; i++) push_word(3'(i), 8'(8'h31 * (i + 1)));
    drain();
    chk("burst_starts", 32'(starts.size()), 7);
    for (int i = 1; i < starts.size(); i++)
      chk("burst_period", 32'(starts[i] - starts[i-1]), 10);
    check_stream("burst");

    // Push coinciding with IDLE pop at count 3
    for (int i = 0; i < 4; i++) push_word(3'd2, 8'(8'h40 + i));
    idle();
    wait_t(DATA_W);
    @(negedge clk);
    @(negedge clk);
    chk("pre_pop_count", 32'(fifo_count), 3);
    s_valid = 1'b1; s_dest = 3'd6; s_data = 8'h5C;
    @(negedge clk);
    s_valid = 1'b0;
    chk("pushpop_count", 32'(fifo_count), 3);
    chk("pushpop_ready", 32'(s_ready), 1);
    chk("pushpop_en", 32'(demux_en), 1);
    drain();
    check_stream("pushpop");

    // Channel 7 all zeros then channel 0 all ones: sel switches only at the second pop
    push_word(3'd7, 8'h00);
    push_word(3'd0, 8'hFF);
    idle();
    wait_t(DATA_W);
    chk("z_last_sel", 32'(demux_sel), 7);
    chk("z_last_in", 32'(demux_in), 0);
    @(negedge clk);
    chk("z_gap_sel", 32'(demux_sel), 7);
    chk("z_gap_en", 32'(demux_en), 0);
    @(negedge clk);
    chk("z_idle_sel", 32'(demux_sel), 7);
    @(negedge clk);
    chk("o_first_sel", 32'(demux_sel), 0);
    chk("o_first_in", 32'(demux_in), 1);
    drain();
    chk("zo_frames", 32'(out_words.size()), 2);
    if (out_words.size() == 2) begin
      chk("z_word", 32'(out_words[0]), 32'h0000_0000);
      chk("o_word", 32'(out_words[1]), 32'h0000_00FF);
    end
    clear_logs();

    // Reset mid-frame with two words queued
    for (int i = 0; i < 3; i++) push_word(3'd4, 8'(8'hC3 + i));
    idle();
    wait_t(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_en", 32'(demux_en), 0);
    chk("abort_in", 32'(demux_in), 0);
    chk("abort_done", 32'(frame_done), 0);
    chk("abort_count", 32'(fifo_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_abort_en", 32'(demux_en), 0);
    end
    clear_logs();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) push_word(3'($urandom_range(0, 7)), DATA_W'($urandom));
      else idle();
    end
    drain();
    check_stream("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_frame_serializer.md
Name: demux_frame_serializer

Overview:
- Upstream feeder for the 1-to-8 bit-level demultiplexer.
- Accepts parallel words tagged with a 3-bit destination channel over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out LSB-first on a single serial line while holding the channel select stable for the whole frame, so the downstream demux routes every bit of a frame to one output.

Parameters:
- DATA_W, 8: payload width in bits, 2..32.
- FIFO_DEPTH, 4: FIFO entries; power of 2, at least 2.
- GAP_CYCLES, 1: idle cycles inserted after each frame, 0..15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  FIFO can accept a word; registered
- s_dest  in  3  destination channel 0..7
- s_data  in  DATA_W  payload
- demux_in  out  1  serial data to demux in
- demux_sel  out  3  channel select to demux sel
- demux_en  out  1  high while a frame bit is on demux_in
- frame_done  out  1  one-cycle pulse during the last bit of a frame
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async):
  - FIFO emptied; state IDLE.
  - s_ready, demux_in, demux_sel, demux_en, frame_done and fifo_count are all 0.
  - s_ready rises at the first clk edge after rst_n deasserts.
- Handshake:
  - A word is pushed at a clk edge where s_valid && s_ready.
  - s_ready is registered: next value = (next count < FIFO_DEPTH).
  - s_ready is low whenever the FIFO is full; there is no write-through when full.
  - Push and pop at the same edge leave the count unchanged.
  - s_valid while s_ready = 0 has no effect; the source holds the word.
- FSM states: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE:
  - If the FIFO is non-empty at the edge: pop the head, load the shift register with data, load demux_sel with dest, clear the bit counter, go to SHIFT.
  - Otherwise stay in IDLE with demux_en = 0 and demux_in = 0.
- SHIFT:
  - demux_en = 1; demux_in = current LSB of the shift register.
  - The shift register shifts right one bit per cycle.
  - Bit k is visible in the (k+1)th cycle after the pop edge.
  - frame_done = 1 only while bit DATA_W-1 is presented.
  - After DATA_W cycles: go to GAP, or to IDLE if GAP_CYCLES = 0.
- GAP:
  - demux_en = 0, demux_in = 0; demux_sel holds the last channel.
  - Lasts GAP_CYCLES cycles, then goes to IDLE.
- demux_sel changes only on the IDLE pop edge; it never changes mid-frame or in GAP.
- Timing:
  - Word accepted at edge E0 → popped at E1 earliest → bit0 on demux_in during E1..E2.
  - Back-to-back frame start period = DATA_W + GAP_CYCLES + 1 cycles.
- Reset mid-frame: the frame is aborted and FIFO contents are discarded. demux_en and demux_in drop immediately (async); no frame_done is issued.
- fifo_count is exact at all times, saturates at FIFO_DEPTH and never wraps. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Apply rst_n = 0 for 3 cycles, then release → all outputs 0 during reset; s_ready = 1 one edge after release; fifo_count = 0.
- Push dest = 3'b101, data = 8'hA5 → demux_sel = 5 for 8 cycles with demux_en = 1; demux_in = 1,0,1,0,0,1,0,1; frame_done high only with the 8th bit; then 1 gap cycle with demux_en = 0.
- Hold s_valid high for 7 consecutive words with distinct data → s_ready drops when fifo_count = 4 and re-rises after the next pop; frame starts are exactly 10 cycles apart; all 7 frames come out in order with no loss.
- Push exactly when fifo_count = 3 and IDLE pops at the same edge → fifo_count stays 3; s_ready stays 1.
- Push dest = 7 / 8'h00, then dest = 0 / 8'hFF → demux_sel = 7 through its frame and gap, switching to 0 only at the second pop edge; demux_in is all 0s, then all 1s.
- Assert rst_n low after bit 3 of a frame with 2 words queued → demux_en = 0 immediately, no frame_done, fifo_count = 0; no output after release until a new push.
